inst_issue_ctrl: RTL and testbench
==================================

// Module: inst_issue_ctrl
// PURPOSE
//   Sequences the instruction decoder. Buffers fetched instructions in a circular queue and
//   presents one per cycle to the decoder via registered dec_inst/dec_ena. Steers each issued
//   instruction to the reservation station (RS) or the load/store buffer (LSB), and stalls on
//   structural hazards. Sits between the fetcher and the decoder/dispatch stage; cleared by a
//   ROB flush.
// PARAMETERS
//   IQ_DEPTH   8   queue entries; power of 2, >= 2
//   INS_LEN    32  instruction width
//   ADDR_LEN   32  PC width
// PORTS
//   clk          in   1         clock; all state updates on posedge
//   rst          in   1         asynchronous, active-low reset
//   rdy          in   1         global enable; 0 = pause (see behaviour)
//   flush        in   1         ROB mispredict flush, one-cycle pulse
//   fetch_valid  in   1         fetch_inst/fetch_pc valid this cycle
//   fetch_inst   in   INS_LEN   instruction word from fetcher
//   fetch_pc     in   ADDR_LEN  PC of fetch_inst
//   fetch_ready  out  1         queue can accept; combinational
//   rob_full     in   1         ROB has no free slot
//   rs_full      in   1         RS has no free slot
//   lsb_full     in   1         LSB has no free slot
//   dec_ena      out  1         decoder enable; equals issue_valid
//   dec_inst     out  INS_LEN   instruction to decoder (registered)
//   issue_valid  out  1         dec_inst/issue_pc valid; downstream allocates this cycle
//   issue_to_lsb out  1         1 = LSB target, 0 = RS target
//   issue_pc     out  ADDR_LEN  PC of issued instruction
//   ctrl_state   out  2         0 EMPTY, 1 RUN, 2 STALL, 3 FLUSH
//   stall_cnt    out  16        cycles spent in STALL, saturating
// BEHAVIOUR
//   Reset (rst=0, asynchronous):
//     - count, head, tail = 0; issue_valid = 0; issue_to_lsb = 0
//     - dec_inst = 0; issue_pc = 0; ctrl_state = EMPTY; stall_cnt = 0
//   Push:
//     - fetch_ready = (count < IQ_DEPTH) && ctrl_state != FLUSH
//     - push = fetch_valid && fetch_ready && rdy && !flush
//     - full queue refuses a push even when a pop occurs in the same cycle
//   Head classification:
//     - opcode inst[6:0]: 0000011 (load) or 0100011 (store) -> LSB
//     - 0110111, 0010111, 1101111, 1100111, 1100011, 0010011, 0110011 -> RS
//     - any other opcode -> illegal
//   Pop/issue (count!=0, rdy, !flush):
//     - illegal head: popped silently, no slot needed, issue_valid<=0
//     - legal head with !rob_full and target not full: pop; next edge issue_valid<=1,
//       dec_inst<=head inst, issue_pc<=head pc, issue_to_lsb<=class
//     - otherwise: no pop, issue_valid<=0
//     - latency: push at edge N -> earliest issue_valid at edge N+2; no empty-queue bypass
//     - one issue per cycle max; push and pop in the same cycle allowed; count updates by net
//   Pointers: head/tail are log2(IQ_DEPTH) bits and wrap modulo IQ_DEPTH
//   rdy=0: queue, pointers, state and stall_cnt hold; issue_valid<=0; no push/pop
//   FSM (evaluated when rdy=1):
//     - flush -> FLUSH from any state; count, head, tail <= 0; issue_valid <= 0
//     - FLUSH -> EMPTY after exactly one cycle
//     - EMPTY -> RUN when next count != 0
//     - RUN/STALL -> STALL when next count != 0 and legal head is blocked;
//       -> RUN when next count != 0 and head is issuable; -> EMPTY when next count == 0
//   stall_cnt: +1 on each rdy=1 cycle in STALL; saturates at 16'hFFFF; cleared only by reset
//   Reset mid-operation: all state cleared immediately; in-flight issue_valid dropped
// TESTING
//   1. Push addi(0x00100093) pc=0x0 -> issue_valid=1 two edges later, issue_to_lsb=0,
//      dec_inst=0x00100093
//   2. Push lw(0x0000A103), lsb_full=1 -> ctrl_state=STALL, stall_cnt increments;
//      lsb_full=0 -> issue with issue_to_lsb=1
//   3. Push 8 instructions with rob_full=1 -> fetch_ready=0 at count=8;
//      release -> 8 issues in order, pc 0x0..0x1C, head wraps
//   4. Queue holds 5, flush=1 -> next cycle ctrl_state=FLUSH, fetch_ready=0,
//      count=0; one cycle later EMPTY
//   5. Push 0xFFFFFFFF then add(0x002081B3) -> illegal popped, no issue_valid;
//      only add issued
//   6. rdy=0 for 3 cycles during a stream -> no issue_valid, count held;
//      rdy=1 -> issue order resumes unchanged; reset mid-stream -> all outputs zero

Source files
------------

// File: rtl/inst_issue_ctrl_if.sv
// Fetch-side and issue-side handshake bundle for inst_issue_ctrl.
// The controller uses the slave modport and the fetcher/decoder side uses the master modport.
interface inst_issue_ctrl_if #(
    parameter int INS_LEN  = 32,
    parameter int ADDR_LEN = 32
);
    logic                fetch_valid;
    logic [INS_LEN-1:0]  fetch_inst;
    logic [ADDR_LEN-1:0] fetch_pc;
    logic                fetch_ready;
    logic                rob_full;
    logic                rs_full;
    logic                lsb_full;
    logic                dec_ena;
    logic [INS_LEN-1:0]  dec_inst;
    logic                issue_valid;
    logic                issue_to_lsb;
    logic [ADDR_LEN-1:0] issue_pc;

    modport slave (
        input  fetch_valid, fetch_inst, fetch_pc, rob_full, rs_full, lsb_full,
        output fetch_ready, dec_ena, dec_inst, issue_valid, issue_to_lsb, issue_pc
    );

    modport master (
        output fetch_valid, fetch_inst, fetch_pc, rob_full, rs_full, lsb_full,
        input  fetch_ready, dec_ena, dec_inst, issue_valid, issue_to_lsb, issue_pc
    );
endinterface

// File: rtl/inst_issue_ctrl.sv
// Instruction queue and issue sequencer feeding the decoder.
// It steers each issued instruction to the RS or the LSB and stalls while the target is full.
module inst_issue_ctrl #(
    parameter int IQ_DEPTH = 8,
    parameter int INS_LEN  = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    input  logic              flush,
    inst_issue_ctrl_if.slave  bus,
    output logic [1:0]        ctrl_state,
    output logic [15:0]       stall_cnt
);
    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(IQ_DEPTH);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STALL = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    logic [INS_LEN-1:0]  inst_mem [IQ_DEPTH];
    logic [ADDR_LEN-1:0] pc_mem   [IQ_DEPTH];

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic                issue_valid_q, issue_valid_d;
    logic                issue_to_lsb_q, issue_to_lsb_d;
    logic [INS_LEN-1:0]  dec_inst_q, dec_inst_d;
    logic [ADDR_LEN-1:0] issue_pc_q, issue_pc_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;

    logic [INS_LEN-1:0]  head_inst;
    logic [ADDR_LEN-1:0] head_pc;
    logic                head_legal;
    logic                head_lsb;
    logic                q_empty;
    logic                active;
    logic                fetch_ready;
    logic                target_full;
    logic                head_issuable;
    logic                head_blocked;
    logic                push;
    logic                pop;

    assign head_inst = inst_mem[head_q];
    assign head_pc   = pc_mem[head_q];
    assign q_empty   = (count_q == '0);
    assign active    = rdy && !flush;

    always_comb begin
        head_legal = 1'b1;
        head_lsb   = 1'b0;
        case (head_inst[6:0])
            7'b0000011, 7'b0100011: head_lsb = 1'b1;
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
            7'b1100011, 7'b0010011, 7'b0110011: head_lsb = 1'b0;
            default: head_legal = 1'b0;
        endcase
    end

    assign target_full   = head_lsb ? bus.lsb_full : bus.rs_full;
    assign head_issuable = !q_empty && head_legal && !bus.rob_full && !target_full;
    assign head_blocked  = !q_empty && head_legal && !head_issuable;

    // Illegal heads are discarded without needing a downstream slot.
    assign pop  = active && !q_empty && (!head_legal || head_issuable);

    // The full check uses the current count, so a full queue refuses even when popping.
    assign fetch_ready = (count_q < DEPTH_CNT) && (state_q != ST_FLUSH);
    assign push        = bus.fetch_valid && fetch_ready && active;

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        head_d         = head_q;
        tail_d         = tail_q;
        issue_valid_d  = 1'b0;
        issue_to_lsb_d = issue_to_lsb_q;
        dec_inst_d     = dec_inst_q;
        issue_pc_d     = issue_pc_q;
        stall_cnt_d    = stall_cnt_q;

        if (rdy) begin
            if (state_q == ST_STALL && stall_cnt_q != 16'hFFFF)
                stall_cnt_d = stall_cnt_q + 16'd1;

            if (flush) begin
                state_d = ST_FLUSH;
                count_d = '0;
                head_d  = '0;
                tail_d  = '0;
            end else begin
                if (pop)
                    head_d = head_q + PTR_W'(1);
                if (push)
                    tail_d = tail_q + PTR_W'(1);
                count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};

                if (pop && head_legal) begin
                    issue_valid_d  = 1'b1;
                    dec_inst_d     = head_inst;
                    issue_pc_d     = head_pc;
                    issue_to_lsb_d = head_lsb;
                end

                case (state_q)
                    ST_FLUSH: state_d = ST_EMPTY;
                    ST_EMPTY: state_d = (count_d != '0) ? ST_RUN : ST_EMPTY;
                    default: begin
                        if (count_d == '0)
                            state_d = ST_EMPTY;
                        else if (head_blocked)
                            state_d = ST_STALL;
                        else
                            state_d = ST_RUN;
                    end
                endcase
            end
        end
    end

    // Queue storage carries no reset; only entries between head and tail are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail_q] <= bus.fetch_inst;
            pc_mem[tail_q]   <= bus.fetch_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_EMPTY;
            count_q        <= '0;
            head_q         <= '0;
            tail_q         <= '0;
            issue_valid_q  <= 1'b0;
            issue_to_lsb_q <= 1'b0;
            dec_inst_q     <= '0;
            issue_pc_q     <= '0;
            stall_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            issue_valid_q  <= issue_valid_d;
            issue_to_lsb_q <= issue_to_lsb_d;
            dec_inst_q     <= dec_inst_d;
            issue_pc_q     <= issue_pc_d;
            stall_cnt_q    <= stall_cnt_d;
        end
    end

    assign bus.fetch_ready  = fetch_ready;
    assign bus.dec_ena      = issue_valid_q;
    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_to_lsb = issue_to_lsb_q;
    assign bus.dec_inst     = dec_inst_q;
    assign bus.issue_pc     = issue_pc_q;
    assign ctrl_state       = state_q;
    assign stall_cnt        = stall_cnt_q;
endmodule

// File: tb/tb_inst_issue_ctrl.sv
// Self-checking bench for inst_issue_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_inst_issue_ctrl;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cnt;

    inst_issue_ctrl_if #(.INS_LEN(32), .ADDR_LEN(32)) bus ();

    inst_issue_ctrl #(.IQ_DEPTH(DEPTH), .INS_LEN(32), .ADDR_LEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rdy        (rdy),
        .flush      (flush),
        .bus        (bus.slave),
        .ctrl_state (ctrl_state),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t      mq[$];
    int          m_state;
    int unsigned m_stall;
    bit          m_valid;
    bit          m_lsb;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_fail = 0;

    // 0 = RS, 1 = LSB, 2 = illegal
    function automatic int classify(logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        if (op inside {7'h03, 7'h23}) return 1;
        if (op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h13, 7'h33}) return 0;
        return 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_stall = 0;
        m_valid = 1'b0;
        m_lsb   = 1'b0;
        m_inst  = '0;
        m_pc    = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        entry_t e;
        entry_t n;
        int     k;
        int     sz0;
        bit     blocked;
        m_valid = 1'b0;
        if (!rdy) return;
        if (m_state == 2 && m_stall < 32'hFFFF) m_stall++;
        if (flush) begin
            mq.delete();
            m_state = 3;
            return;
        end
        blocked = 1'b0;
        sz0 = mq.size();
        if (sz0 > 0) begin
            e = mq[0];
            k = classify(e.inst);
            if (k == 2) begin
                void'(mq.pop_front());
            end else if (!bus.rob_full && !((k == 1) ? bus.lsb_full : bus.rs_full)) begin
                void'(mq.pop_front());
                m_valid = 1'b1;
                m_inst  = e.inst;
                m_pc    = e.pc;
                m_lsb   = (k == 1);
            end else begin
                blocked = 1'b1;
            end
        end
        if (bus.fetch_valid && sz0 < DEPTH && m_state != 3) begin
            n.inst = bus.fetch_inst;
            n.pc   = bus.fetch_pc;
            mq.push_back(n);
        end
        if (m_state == 3)          m_state = 0;
        else if (mq.size() == 0)   m_state = 0;
        else if (m_state == 0)     m_state = 1;
        else                       m_state = blocked ? 2 : 1;
    endtask

    task automatic compare();
        chk("issue_valid", {31'd0, bus.issue_valid}, {31'd0, m_valid});
        chk("dec_ena", {31'd0, bus.dec_ena}, {31'd0, m_valid});
        chk("ctrl_state", {30'd0, ctrl_state}, 32'(m_state));
        chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
        chk("fetch_ready", {31'd0, bus.fetch_ready},
            {31'd0, (mq.size() < DEPTH) && (m_state != 3)});
        if (m_valid) begin
            chk("dec_inst", bus.dec_inst, m_inst);
            chk("issue_pc", bus.issue_pc, m_pc);
            chk("issue_to_lsb", {31'd0, bus.issue_to_lsb}, {31'd0, m_lsb});
            $display("issue pc=0x%08h inst=0x%08h to_lsb=%0d", m_pc, m_inst, m_lsb);
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive_fetch(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.fetch_valid = v;
        bus.fetch_inst  = inst;
        bus.fetch_pc    = pc;
    endtask

    logic [31:0] inst_tab [8];
    logic [31:0] rpc;

    initial begin
        inst_tab[0] = 32'h00100093;  // addi
        inst_tab[1] = 32'h0000A103;  // lw
        inst_tab[2] = 32'h0020A023;  // sw
        inst_tab[3] = 32'h002081B3;  // add
        inst_tab[4] = 32'h000012B7;  // lui
        inst_tab[5] = 32'h00208463;  // beq
        inst_tab[6] = 32'hFFFFFFFF;  // illegal
        inst_tab[7] = 32'h0000000B;  // illegal (custom-0)

        drive_fetch(1'b0, '0, '0);
        bus.rob_full = 1'b0;
        bus.rs_full  = 1'b0;
        bus.lsb_full = 1'b0;
        rdy = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_issue_valid", {31'd0, bus.issue_valid}, 32'd0);
        chk("rst_dec_inst", bus.dec_inst, 32'd0);
        chk("rst_issue_pc", bus.issue_pc, 32'd0);
        chk("rst_ctrl_state", {30'd0, ctrl_state}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        rst_n = 1'b1;

        // addi: presented after E0, queued at E1, issued at E2
        drive_fetch(1'b1, 32'h00100093, 32'h0);
        step();
        drive_fetch(1'b0, '0, '0);
        chk("t1_not_yet", {31'd0, bus.issue_valid}, 32'd0);
        step();
        chk("t1_valid", {31'd0, bus.issue_valid}, 32'd1);
        chk("t1_inst", bus.dec_inst, 32'h00100093);
        chk("t1_to_lsb", {31'd0, bus.issue_to_lsb}, 32'd0);
        step();

        // lw blocked by a full LSB
        bus.lsb_full = 1'b1;
        drive_fetch(1'b1, 32'h0000A103, 32'h4);
        step();
        drive_fetch(1'b0, '0, '0);
        step();
        chk("t2_stall_state", {30'd0, ctrl_state}, 32'd2);
        step();
        step();
        chk("t2_stall_cnt", {16'd0, stall_cnt}, 32'd2);
        bus.lsb_full = 1'b0;
        step();
        chk("t2_valid", {31'd0, bus.issue_valid}, 32'd1);
        chk("t2_to_lsb", {31'd0, bus.issue_to_lsb}, 32'd1);
        chk("t2_inst", bus.dec_inst, 32'h0000A103);
        step();

        // fill the queue while the ROB is full, then drain in order
        bus.rob_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_fetch(1'b1, 32'h00100093, 32'(i * 4));
            step();
        end
        chk("t3_full_ready", {31'd0, bus.fetch_ready}, 32'd0);
        drive_fetch(1'b1, 32'h00100093, 32'h20);
        step();
        drive_fetch(1'b0, '0, '0);
        bus.rob_full = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("t3_valid", {31'd0, bus.issue_valid}, 32'd1);
            chk("t3_pc", bus.issue_pc, 32'(i * 4));
        end
        step();
        chk("t3_refused_drop", {31'd0, bus.issue_valid}, 32'd0);

        // flush with five queued entries
        bus.rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_fetch(1'b1, 32'h002081B3, 32'h40 + 32'(i * 4));
            step();
        end
        drive_fetch(1'b0, '0, '0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t4_flush_state", {30'd0, ctrl_state}, 32'd3);
        chk("t4_flush_ready", {31'd0, bus.fetch_ready}, 32'd0);
        step();
        chk("t4_empty_state", {30'd0, ctrl_state}, 32'd0);
        chk("t4_empty_ready", {31'd0, bus.fetch_ready}, 32'd1);
        bus.rob_full = 1'b0;

        // illegal word dropped, following add issued
        drive_fetch(1'b1, 32'hFFFFFFFF, 32'h100);
        step();
        drive_fetch(1'b1, 32'h002081B3, 32'h104);
        step();
        drive_fetch(1'b0, '0, '0);
        chk("t5_no_issue", {31'd0, bus.issue_valid}, 32'd0);
        step();
        chk("t5_add_valid", {31'd0, bus.issue_valid}, 32'd1);
        chk("t5_add_pc", bus.issue_pc, 32'h104);
        chk("t5_add_inst", bus.dec_inst, 32'h002081B3);
        step();

        // pause during a stream
        bus.rs_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_fetch(1'b1, 32'h00100093, 32'h200 + 32'(i * 4));
            step();
        end
        bus.rs_full = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_paused", {31'd0, bus.issue_valid}, 32'd0);
        end
        rdy = 1'b1;
        drive_fetch(1'b0, '0, '0);
        step();
        chk("t6_resume_pc", bus.issue_pc, 32'h200);
        repeat (4) step();

        // asynchronous reset in the middle of a stream
        drive_fetch(1'b1, 32'h0000A103, 32'h300);
        step();
        drive_fetch(1'b1, 32'h00100093, 32'h304);
        step();
        drive_fetch(1'b0, '0, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {31'd0, bus.issue_valid}, 32'd0);
        chk("t6_rst_inst", bus.dec_inst, 32'd0);
        chk("t6_rst_pc", bus.issue_pc, 32'd0);
        chk("t6_rst_lsb", {31'd0, bus.issue_to_lsb}, 32'd0);
        chk("t6_rst_state", {30'd0, ctrl_state}, 32'd0);
        chk("t6_rst_stall", {16'd0, stall_cnt}, 32'd0);
        chk("t6_rst_ready", {31'd0, bus.fetch_ready}, 32'd1);
        model_reset();
        #1 rst_n = 1'b1;

        // randomized traffic
        rpc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            rdy          = ($urandom_range(0, 9) != 0);
            flush        = ($urandom_range(0, 59) == 0);
            bus.rob_full = ($urandom_range(0, 4) == 0);
            bus.rs_full  = ($urandom_range(0, 4) == 0);
            bus.lsb_full = ($urandom_range(0, 2) == 0);
            drive_fetch($urandom_range(0, 9) < 7, inst_tab[$urandom_range(0, 7)], rpc);
            rpc = rpc + 32'd4;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
